tank_move_ctrl: RTL



---
 rtl/tank_pkg.sv | 33 +++
 rtl/tank_step_timer.sv | 41 ++++
 rtl/tank_move_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared constants and types for the tank blocks (movement control and renderer).
//   - Direction encodings as driven on tank_dir.
//   - Playfield grid limits and pixel mapping: cell (x, y) -> (x*CELL_PX+PIX_X0, y*CELL_PX+PIX_Y0).
//   - Movement FSM state type and a helper that sizes the shared counters.
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_DEAD
    } move_state_e;

    localparam int unsigned X_MAX   = 23;
    localparam int unsigned Y_MAX   = 21;
    localparam int unsigned PIX_X0  = 160;
    localparam int unsigned PIX_Y0  = 40;
    localparam int unsigned CELL_PX = 20;

    // Width able to hold a count up to the larger of the two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/tank_step_timer.sv
// Loadable terminal-count counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (wins over en_i)
//   en_i       : count enable; wraps to 0 after reaching term_i
//   term_i     : terminal count value
//   done_o     : high while the count equals term_i (caller qualifies with its enable)
module tank_step_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == term_i) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Driven from the register only, so the caller can use it in the same
    // combinational block that generates en_i/clr_i without a loop.
    assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/tank_move_ctrl.sv
// Tank movement controller: debounced buttons -> grid position, facing, alive flag.
//   clk, rst_n            : clock, asynchronous active-low reset
//   btn_up/down/left/right: debounced levels, priority up > down > left > right
//   hit                   : single-cycle destroy pulse
//   x_rel_pos, y_rel_pos  : current cell
//   tank_dir              : facing (tank_pkg::dir_e encoding)
//   tank_state            : 1 = alive/visible
//   step_pulse            : one cycle per completed cell move
module tank_move_ctrl #(
    parameter int unsigned X_MAX          = 23,
    parameter int unsigned Y_MAX          = 21,
    parameter int unsigned X_START        = 11,
    parameter int unsigned Y_START        = 21,
    parameter logic [1:0]  DIR_START      = 2'b00,
    parameter int unsigned STEP_CYCLES    = 5_000_000,
    parameter int unsigned RESPAWN_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       hit,
    output logic [4:0] x_rel_pos,
    output logic [4:0] y_rel_pos,
    output logic [1:0] tank_dir,
    output logic       tank_state,
    output logic       step_pulse
);

    import tank_pkg::*;

    localparam int unsigned CW = cnt_width(STEP_CYCLES, RESPAWN_CYCLES);
    localparam logic [CW-1:0] STEP_TERM = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] RESP_TERM = CW'(RESPAWN_CYCLES - 1);

    move_state_e state_q, state_d;
    logic [4:0]  x_q, x_d, y_q, y_d;
    dir_e        dir_q, dir_d;
    logic        alive_q, alive_d;
    logic        step_q, step_d;

    logic        req_valid;
    dir_e        req_dir;
    logic        blocked;
    logic        step_clr, step_en, step_done;
    logic        resp_clr, resp_en, resp_done;

    // Button decode
    always_comb begin
        req_valid = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)         req_dir = DIR_UP;
        else if (btn_down)  req_dir = DIR_DOWN;
        else if (btn_left)  req_dir = DIR_LEFT;
        else                req_dir = DIR_RIGHT;
    end

    // Edge check precedes inc/dec so the 5-bit positions never wrap.
    always_comb begin
        case (dir_q)
            DIR_UP:    blocked = (y_q == 5'd0);
            DIR_DOWN:  blocked = (y_q == 5'(Y_MAX));
            DIR_LEFT:  blocked = (x_q == 5'd0);
            default:   blocked = (x_q == 5'(X_MAX));
        endcase
    end

    tank_step_timer #(.WIDTH(CW)) u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (step_clr),
        .en_i   (step_en),
        .term_i (STEP_TERM),
        .done_o (step_done)
    );

    tank_step_timer #(.WIDTH(CW)) u_respawn_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (resp_clr),
        .en_i   (resp_en),
        .term_i (RESP_TERM),
        .done_o (resp_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; hit is ignored once already dead.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hit)            state_d = ST_DEAD;
                else if (req_valid) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hit)             state_d = ST_DEAD;
                else if (!req_valid) state_d = ST_IDLE;
            end
            ST_DEAD: begin
                if (resp_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values and timer controls.
    // The step timer only runs while holding the direction already faced; any
    // turn, release, hit or other state clears it.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        alive_d  = alive_q;
        step_d   = 1'b0;
        step_clr = 1'b1;
        step_en  = 1'b0;
        resp_clr = 1'b1;
        resp_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    alive_d = 1'b0;
                end else if (req_valid) begin
                    dir_d = req_dir;
                end
            end
            ST_HOLD: begin
                if (hit) begin
                    alive_d = 1'b0;
                end else if (req_valid) begin
                    if (req_dir != dir_q) begin
                        dir_d = req_dir;
                    end else begin
                        step_clr = 1'b0;
                        step_en  = 1'b1;
                        if (step_done && !blocked) begin
                            step_d = 1'b1;
                            case (dir_q)
                                DIR_UP:    y_d = y_q - 5'd1;
                                DIR_DOWN:  y_d = y_q + 5'd1;
                                DIR_LEFT:  x_d = x_q - 5'd1;
                                default:   x_d = x_q + 5'd1;
                            endcase
                        end
                    end
                end
            end
            ST_DEAD: begin
                resp_clr = 1'b0;
                resp_en  = 1'b1;
                if (resp_done) begin
                    x_d     = 5'(X_START);
                    y_d     = 5'(Y_START);
                    dir_d   = dir_e'(DIR_START);
                    alive_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= 5'(X_START);
            y_q     <= 5'(Y_START);
            dir_q   <= dir_e'(DIR_START);
            alive_q <= 1'b1;
            step_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            alive_q <= alive_d;
            step_q  <= step_d;
        end
    end

    assign x_rel_pos  = x_q;
    assign y_rel_pos  = y_q;
    assign tank_dir   = dir_q;
    assign tank_state = alive_q;
    assign step_pulse = step_q;

endmodule
